// File: rtl/volts_scale_ctrl.sv
// volts_scale_ctrl: one-hot volts-scale select for the sample-scaling stage.
// Manual mode steps the scale from debounced up/down pushbuttons.
// Auto mode steps it from windowed peak detection on the sample stream.
module volts_scale_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 40000,
  parameter int unsigned WINDOW          = 4096,
  parameter logic [7:0]  AUTO_HI         = 8'd200,
  parameter logic [7:0]  AUTO_LO         = 8'd3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       auto_en,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  output logic [2:0] volts_scale,
  output logic       scale_changed,
  output logic [7:0] window_peak
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CNT_W = $clog2(WINDOW);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  // The state encoding is the one-hot output itself, so volts_scale is a pure register.
  typedef enum logic [2:0] {
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b100
  } scale_t;

  // Bit 0 = up button, bit 1 = down button.
  logic [1:0]      btn_raw_s;
  logic [1:0]      sync1_r;
  logic [1:0]      sync2_r;
  logic [1:0]      deb_r;
  logic [1:0]      deb_d_r;
  logic [1:0]      evt_r;
  logic [DB_W-1:0] db_cnt_r [2];

  logic            auto_d_r;
  logic            toggle_s;
  logic            take_s;
  logic            last_s;
  logic [7:0]      eval_peak_s;
  logic [7:0]      cur_peak_r;
  logic [7:0]      window_peak_r;
  logic [CNT_W-1:0] count_r;

  scale_t          state_r;
  scale_t          next_s;
  logic            up_req_s;
  logic            dn_req_s;
  logic            scale_changed_r;

  assign btn_raw_s = {btn_down, btn_up};

  // Synchronize, debounce and edge-detect both buttons; events are registered 1-cycle pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
      deb_r   <= 2'b00;
      deb_d_r <= 2'b00;
      evt_r   <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= btn_raw_s;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      evt_r   <= deb_r & ~deb_d_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (db_cnt_r[i] == DB_LAST) begin
          deb_r[i]    <= sync2_r[i];
          db_cnt_r[i] <= '0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
        end
      end
    end
  end

  // A mode change drops the in-flight window and any sample or step in that cycle.
  assign toggle_s    = auto_en ^ auto_d_r;
  assign take_s      = sample_valid & ~toggle_s;
  assign last_s      = take_s & (count_r == CNT_LAST);
  assign eval_peak_s = (sample > cur_peak_r) ? sample : cur_peak_r;

  // Windowed peak tracker; publishes the window maximum when the last sample arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_d_r      <= 1'b0;
      cur_peak_r    <= 8'd0;
      window_peak_r <= 8'd0;
      count_r       <= '0;
    end else begin
      auto_d_r <= auto_en;
      if (toggle_s) begin
        cur_peak_r <= 8'd0;
        count_r    <= '0;
      end else if (last_s) begin
        window_peak_r <= eval_peak_s;
        cur_peak_r    <= 8'd0;
        count_r       <= '0;
      end else if (take_s) begin
        cur_peak_r <= eval_peak_s;
        count_r    <= count_r + CNT_W'(1);
      end else begin
        cur_peak_r <= cur_peak_r;
        count_r    <= count_r;
      end
    end
  end

  // Step requests from the active source, then saturating next-state selection.
  always_comb begin
    up_req_s = 1'b0;
    dn_req_s = 1'b0;
    next_s   = state_r;
    if (toggle_s) begin
      up_req_s = 1'b0;
      dn_req_s = 1'b0;
    end else if (auto_en) begin
      up_req_s = last_s & (eval_peak_s > AUTO_HI);
      dn_req_s = last_s & (eval_peak_s < AUTO_LO);
    end else begin
      up_req_s = evt_r[0] & ~evt_r[1];
      dn_req_s = evt_r[1] & ~evt_r[0];
    end
    case (state_r)
      S1: begin
        if (up_req_s) next_s = S2;
        else          next_s = S1;
      end
      S2: begin
        if (up_req_s)      next_s = S3;
        else if (dn_req_s) next_s = S1;
        else               next_s = S2;
      end
      S3: begin
        if (dn_req_s) next_s = S2;
        else          next_s = S3;
      end
      default: next_s = S1;
    endcase
  end

  // Scale state register and change pulse aligned with the first cycle of a new value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= S1;
      scale_changed_r <= 1'b0;
    end else begin
      state_r         <= next_s;
      scale_changed_r <= (next_s != state_r);
    end
  end

  assign volts_scale   = state_r;
  assign scale_changed = scale_changed_r;
  assign window_peak   = window_peak_r;

endmodule
